pio_key_event_poller: RTL and testbench
=======================================

Name: pio_key_event_poller

Overview:
- Avalon-MM master that services the 4-key edge-capturing PIO without CPU involvement.
- Sequence per poll:
  - read the edge-capture register;
  - clear it;
  - read the live key levels;
  - apply per-key debounce hold-off;
  - push a key event into a small FIFO.
- Sits between the key PIO slave port and a consumer (CPU-facing register block or hardware menu logic).
- Turns raw, bouncing edge captures into clean, rate-limited events.

Parameters:
- NKEYS, 4, number of keys / PIO data width (1..8).
- POLL_CYCLES, 50000, clk cycles between poll sequence starts (1 ms at 50 MHz); minimum 8.
- HOLDOFF_CYCLES, 1000000, cycles a key stays locked after an accepted edge (20 ms at 50 MHz).
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_address  out  2  PIO register address (0 = data, 3 = edge capture)
- m_chipselect  out  1  PIO chip select
- m_write_n  out  1  active-low write strobe
- m_writedata  out  32  write data
- m_readdata  in  32  PIO read data, fixed read latency 1, no waitrequest
- enable  in  1  polling enable
- evt_valid  out  1  FIFO not empty
- evt_data  out  2*NKEYS  {level[NKEYS-1:0], edges[NKEYS-1:0]} of FIFO head
- evt_ready  in  1  consumer pop; pop occurs when evt_valid & evt_ready
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow
- lock_status  out  NKEYS  per-key hold-off active

Behaviour:
- Reset values: m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0, evt_valid=0, evt_data=0, overflow=0, lock_status=0. FSM in IDLE, poll timer=0, FIFO empty, all hold-off counters 0.
- Poll timer counts while enable=1; it reloads to 0 when enable=0.
- When the timer reaches POLL_CYCLES-1: timer wraps to 0 and the FSM leaves IDLE. If the FSM is not in IDLE at that moment, the tick is dropped (no queuing).
- FSM states, one cycle each unless stated:
  - IDLE: bus outputs idle (chipselect=0, write_n=1). On tick -> RD_CAP.
  - RD_CAP: chipselect=1, write_n=1, address=3 -> WAIT_CAP.
  - WAIT_CAP: chipselect=0; latch cap = m_readdata[NKEYS-1:0]. If cap == 0 -> IDLE, else -> CLR.
  - CLR: chipselect=1, write_n=0, address=3, writedata=all ones -> RD_LVL.
  - RD_LVL: chipselect=1, write_n=1, address=0 -> WAIT_LVL.
  - WAIT_LVL: latch lvl = m_readdata[NKEYS-1:0] -> PUSH.
  - PUSH: acc = cap & ~lock_status.
    - If acc != 0 and the FIFO is not full: enqueue {lvl, acc}.
    - If acc != 0 and the FIFO is full: overflow <= 1; no enqueue.
    - For each bit set in acc: load that key's hold-off counter with HOLDOFF_CYCLES.
    - -> IDLE.
- A full poll with edges takes 6 cycles; an empty poll takes 2 bus cycles.
- Known window: edges captured by the PIO between RD_CAP and CLR (2 cycles) are cleared and lost. This is accepted because hold-off is far longer than the window.
- Hold-off counters:
  - Each decrements by 1 per cycle while nonzero; lock_status[i] = (counter_i != 0).
  - Edges on locked keys are discarded silently; no overflow.
- FIFO:
  - Synchronous, first-word-fall-through: evt_data is valid whenever evt_valid=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: allowed in every state. When full, pop frees space in the same cycle, so the push succeeds and overflow is not set.
  - Pop when empty is ignored.
- overflow: if overflow_clr and a new drop occur in the same cycle, the set wins.
- enable deasserted mid-sequence: the current sequence completes to IDLE; no further ticks start.
- reset_n asserted mid-sequence: outputs return to reset values asynchronously; FIFO contents and hold-off state are discarded.
- m_writedata is 0 except in CLR.

Test Plan:
- Reset with enable=0: all outputs at reset values; no chipselect activity for 3*POLL_CYCLES.
- Sim params POLL_CYCLES=16, HOLDOFF_CYCLES=100. Pulse key1 via PIO model (cap=0x2, lvl=0x2) -> exact 6-cycle bus sequence addr 3 read / addr 3 write 0xFFFFFFFF / addr 0 read; evt_data=0x22, evt_valid=1; lock_status=0x2 for 100 cycles.
- Bounce key1 10 times within 100 cycles of an accepted edge -> no further events; after lock expiry, a new edge produces a second event.
- FIFO_DEPTH=4, evt_ready=0, edges on 5 distinct unlocked polls -> 4 events held, overflow=1. overflow_clr -> 0. Then pop all -> events in order, evt_valid falls after the 4th pop.
- FIFO full with evt_ready=1 in the PUSH cycle -> push accepted, overflow stays 0, occupancy stays 4.
- Assert reset_n mid-CLR -> m_chipselect=0 and m_write_n=1 immediately; FIFO empty after release; polling resumes from IDLE.

Source files
------------

// File: rtl/pio_key_event_poller_if.sv
// rtl/pio_key_event_poller_if.sv - Avalon-MM master bus between the key poller and the key PIO slave
interface pio_key_event_poller_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/pio_key_event_poller.sv
// rtl/pio_key_event_poller.sv - polls the key PIO edge-capture register, debounces per key, queues events
module pio_key_event_poller #(
  parameter int NKEYS          = 4,
  parameter int POLL_CYCLES    = 50000,
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pio_key_event_poller_if.master bus,
  input  logic                   enable,
  output logic                   evt_valid,
  output logic [2*NKEYS-1:0]     evt_data,
  input  logic                   evt_ready,
  output logic                   overflow,
  input  logic                   overflow_clr,
  output logic [NKEYS-1:0]       lock_status
);
  localparam int TW = $clog2(POLL_CYCLES);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, RD_CAP, WAIT_CAP, CLR, RD_LVL, WAIT_LVL, PUSH} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     poll_cnt;
  logic              tick;
  logic [NKEYS-1:0]  cap, lvl, acc;
  logic [HW-1:0]     hold_cnt [NKEYS];
  logic [2*NKEYS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, pop, push_req, push, drop;
  logic              unused_rdata;

  assign unused_rdata = ^bus.m_readdata;

  assign tick = enable && (poll_cnt == TW'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      poll_cnt <= '0;
    else if (!enable || tick)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.m_chipselect = 1'b0;
    bus.m_write_n    = 1'b1;
    bus.m_address    = 2'd0;
    bus.m_writedata  = '0;
    case (state)
      IDLE:     if (tick) state_nxt = RD_CAP;
      RD_CAP: begin
        bus.m_chipselect = 1'b1;
        bus.m_address    = 2'd3;
        state_nxt        = WAIT_CAP;
      end
      WAIT_CAP: state_nxt = (bus.m_readdata[NKEYS-1:0] == '0) ? IDLE : CLR;
      CLR: begin
        bus.m_chipselect = 1'b1;
        bus.m_write_n    = 1'b0;
        bus.m_address    = 2'd3;
        bus.m_writedata  = '1;
        state_nxt        = RD_LVL;
      end
      RD_LVL: begin
        bus.m_chipselect = 1'b1;
        state_nxt        = WAIT_LVL;
      end
      WAIT_LVL: state_nxt = PUSH;
      PUSH:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap <= '0;
      lvl <= '0;
    end else begin
      if (state == WAIT_CAP) cap <= bus.m_readdata[NKEYS-1:0];
      if (state == WAIT_LVL) lvl <= bus.m_readdata[NKEYS-1:0];
    end
  end

  // Edges on keys still in hold-off are dropped here and never reach the FIFO.
  assign acc      = (state == PUSH) ? (cap & ~lock_status) : '0;
  assign push_req = |acc;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = evt_valid && evt_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NKEYS; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (acc[i])
          hold_cnt[i] <= HW'(HOLDOFF_CYCLES);
        else if (hold_cnt[i] != '0)
          hold_cnt[i] <= hold_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    lock_status = '0;
    for (int i = 0; i < NKEYS; i++) lock_status[i] = (hold_cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {lvl, acc};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  assign evt_valid = (count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_pio_key_event_poller.sv
// tb/tb_pio_key_event_poller.sv - scoreboard bench for the key event poller against a behavioural key PIO
module tb_pio_key_event_poller;
  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       overflow;
  logic       overflow_clr;
  logic [3:0] lock_status;

  logic [3:0]  cap_reg   = 4'h0;
  logic [3:0]  lvl_reg   = 4'h0;
  logic [3:0]  key_edge  = 4'h0;
  logic [31:0] pio_rdata = 32'h0;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0]  q [$];
  logic [35:0] exp_bus [6];

  pio_key_event_poller_if bus();
  assign bus.m_readdata = pio_rdata;

  pio_key_event_poller #(
    .NKEYS(4), .POLL_CYCLES(16), .HOLDOFF_CYCLES(100), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .enable(enable),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .overflow(overflow), .overflow_clr(overflow_clr), .lock_status(lock_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key PIO: write-1-to-clear edge capture at address 3, live levels at address 0, read latency 1.
  always @(posedge clk) begin
    cap_reg <= (cap_reg & ~((bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd3)
                            ? bus.m_writedata[3:0] : 4'h0)) | key_edge;
    if (bus.m_chipselect && bus.m_write_n)
      pio_rdata <= (bus.m_address == 2'd3) ? {28'h0, cap_reg} :
                   (bus.m_address == 2'd0) ? {28'h0, lvl_reg} : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdcap();
    int n = 0;
    @(negedge clk);
    while (!(bus.m_chipselect && bus.m_write_n && bus.m_address == 2'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rdcap_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_unlock();
    int n = 0;
    while (lock_status != 4'h0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("unlock_timeout", {60'd0, lock_status}, 64'd0);
  endtask

  task automatic inject(input logic [3:0] mask, input logic [3:0] lvl);
    key_edge = mask;
    lvl_reg  = lvl;
    @(negedge clk);
    key_edge = 4'h0;
  endtask

  task automatic run_poll(input logic [3:0] mask, input logic [3:0] lvl, input bit expect_evt);
    wait_rdcap();
    inject(mask, lvl);
    wait_rdcap();
    repeat (5) @(negedge clk);
    if (expect_evt) q.push_back({lvl, mask});
    @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int n = 0;
    logic [7:0] e;
    while (!evt_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = q.pop_front();
    check(tag, {55'd0, evt_valid, evt_data}, {55'd0, 1'b1, e});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cs_seen;
    int lock_len;
    exp_bus[0] = {1'b1, 1'b1, 2'd3, 32'h0};
    exp_bus[1] = {1'b0, 1'b1, 2'd0, 32'h0};
    exp_bus[2] = {1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF};
    exp_bus[3] = {1'b1, 1'b1, 2'd0, 32'h0};
    exp_bus[4] = {1'b0, 1'b1, 2'd0, 32'h0};
    exp_bus[5] = {1'b0, 1'b1, 2'd0, 32'h0};

    reset_n      = 1'b0;
    enable       = 1'b0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    #1;
    check("rst_bus", {bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata},
          {1'b0, 1'b1, 2'd0, 32'h0});
    check("rst_evt", {evt_valid, evt_data, overflow, lock_status}, 14'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    cs_seen = 0;
    repeat (48) begin
      @(negedge clk);
      if (bus.m_chipselect) cs_seen++;
    end
    check("disabled_no_cs", cs_seen, 0);

    // Single key1 press: exact bus sequence, event contents, hold-off length.
    enable = 1'b1;
    wait_rdcap();
    inject(4'h2, 4'h2);
    wait_rdcap();
    for (int c = 0; c < 6; c++) begin
      check($sformatf("bus_seq%0d", c),
            {bus.m_chipselect, bus.m_write_n, bus.m_address, bus.m_writedata}, exp_bus[c]);
      @(negedge clk);
    end
    q.push_back(8'h22);
    check("first_evt", {evt_valid, evt_data}, {1'b1, 8'h22});
    check("first_lock", lock_status, 4'h2);
    lock_len = 0;
    while (lock_status[1] && lock_len < 300) begin
      lock_len++;
      @(negedge clk);
    end
    check("lock_len", lock_len, 100);
    pop_check("evt_key1");

    // Bouncing while locked yields nothing; a later edge yields a second event.
    run_poll(4'h2, 4'h2, 1'b1);
    for (int b = 0; b < 10; b++) begin
      inject(4'h2, (b % 2 == 0) ? 4'h0 : 4'h2);
      repeat (5) @(negedge clk);
    end
    wait_unlock();
    repeat (20) @(negedge clk);
    pop_check("bounce_accepted");
    check("bounce_no_extra", evt_valid, 1'b0);
    run_poll(4'h2, 4'h0, 1'b1);
    pop_check("after_lock_evt");

    // Overflow with the consumer stalled.
    wait_unlock();
    for (int k = 0; k < 4; k++) run_poll(4'(1 << k), 4'(1 << k), 1'b1);
    while (lock_status[0]) @(negedge clk);
    check("pre_ovf", overflow, 1'b0);
    run_poll(4'h1, 4'h1, 1'b0);
    check("ovf_set", {overflow, evt_valid}, 2'b11);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("drain_ovf%0d", k));
    check("empty_after_drain", evt_valid, 1'b0);

    // Full FIFO with a pop in the PUSH cycle: push accepted, no overflow.
    wait_unlock();
    for (int k = 0; k < 4; k++) run_poll(4'(1 << k), 4'(k + 4), 1'b1);
    wait_unlock();
    wait_rdcap();
    inject(4'h1, 4'hF);
    wait_rdcap();
    repeat (5) @(negedge clk);
    check("pp_front", {evt_valid, evt_data}, {1'b1, q.pop_front()});
    evt_ready = 1'b1;
    q.push_back(8'hF1);
    @(negedge clk);
    evt_ready = 1'b0;
    check("pp_no_ovf", overflow, 1'b0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("drain_pp%0d", k));
    check("pp_occupancy4", evt_valid, 1'b0);

    // Reset asserted in the middle of CLR.
    wait_unlock();
    run_poll(4'h4, 4'h4, 1'b1);
    wait_rdcap();
    inject(4'h8, 4'h8);
    wait_rdcap();
    @(negedge clk);
    @(negedge clk);
    check("in_clr", {bus.m_chipselect, bus.m_write_n, bus.m_address}, {1'b1, 1'b0, 2'd3});
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_bus", {bus.m_chipselect, bus.m_write_n, bus.m_writedata}, {1'b1 ^ 1'b1, 1'b1, 32'h0});
    check("rst_mid_evt", {evt_valid, lock_status}, 5'h0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check("post_rst_empty", {evt_valid, overflow, lock_status}, 6'h0);
    q.push_back(8'h88);
    pop_check("post_rst_evt");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
